// File: rtl/UART_MIKE_pkg.sv
// UART_MIKE_pkg: UART byte width, bridge command/response bytes and the
// bridge FSM state encoding.
package UART_MIKE_pkg;

  localparam int UART_DATA_WIDTH = 8;

  // Command bytes accepted at the start of a frame
  localparam logic [UART_DATA_WIDTH-1:0] CMD_WRITE   = 8'h57;  // 'W'
  localparam logic [UART_DATA_WIDTH-1:0] CMD_READ    = 8'h52;  // 'R'

  // Single-byte responses
  localparam logic [UART_DATA_WIDTH-1:0] RSP_OK      = 8'h4B;  // 'K'
  localparam logic [UART_DATA_WIDTH-1:0] RSP_BAD_CMD = 8'h3F;  // '?'
  localparam logic [UART_DATA_WIDTH-1:0] RSP_PARITY  = 8'h45;  // 'E'

  typedef enum logic [2:0] {
    IDLE,
    CMD_ADDR,
    CMD_DATA,
    MMIO_WR,
    MMIO_RD,
    TX_LOAD,
    TX_WAIT
  } bridge_state_e;

endpackage : UART_MIKE_pkg

// File: rtl/risc_v_mike_pkg.sv
// risc_v_mike_pkg: shared bus widths for the MMIO fabric.
package risc_v_mike_pkg;

  localparam int ADDRESS_32_W = 32;
  localparam int DATA_32_W    = 32;

endpackage : risc_v_mike_pkg

// File: rtl/uart_mmio_bridge.sv
// uart_mmio_bridge: turns UART byte frames into single 32-bit MMIO accesses.
// Frame: command byte, 4 address bytes LSB first, then 4 data bytes LSB first
// for writes. Writes answer 'K', reads answer the 4 read bytes LSB first,
// unknown commands answer '?', parity errors answer 'E'.
// Optional feature: define UART_BRIDGE_TIMEOUT_EN to drop a partial frame
// after TIMEOUT_CYCLES clocks without a received byte.
module uart_mmio_bridge
  import UART_MIKE_pkg::*;
  import risc_v_mike_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [UART_DATA_WIDTH-1:0] rx_data,
  input  logic                       rx_flag,
  input  logic                       parity_error,
  output logic                       rx_flag_clr,
  output logic [UART_DATA_WIDTH-1:0] tx_data,
  output logic                       tx_send,
  input  logic                       tx_flag,
  output logic                       tx_flag_clr,
  output logic [ADDRESS_32_W-1:0]    data_mmio_addr,
  output logic                       data_mmio_wr_addr_val,
  output logic [DATA_32_W-1:0]       data_mmio_wr_data,
  input  logic [DATA_32_W-1:0]       data_mmio_rd_data,
  output logic                       busy
);

  localparam logic [1:0] LAST_FIELD_BYTE = 2'd3;

  bridge_state_e               state_q, state_d;
  logic                        is_write_q;
  logic [1:0]                  byte_cnt_q;
  logic [ADDRESS_32_W-1:0]     addr_q;
  logic [DATA_32_W-1:0]        data_q;
  logic [DATA_32_W-1:0]        txq_q;      // response bytes, next byte in [7:0]
  logic [2:0]                  tx_left_q;  // response bytes not yet acknowledged
  logic                        rx_skip_q;  // cycle after an accept: rx_flag is stale
  logic                        rd_wait_q;  // second MMIO_RD cycle: read data valid

  logic                        rx_ready;
  logic                        accept, shift_addr, shift_data;
  logic                        load_rsp, load_rd;
  logic [UART_DATA_WIDTH-1:0]  rsp_byte;
  logic                        send_c, flag_clr_c, wr_c;
  logic                        timeout_hit;

  assign rx_ready = rx_flag && !rx_skip_q;

`ifdef UART_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] gap_cnt_q;

  assign timeout_hit = (gap_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Count byte-free cycles while a frame is being assembled
  always_ff @(posedge clk) begin
    if (rst || accept || !(state_q inside {CMD_ADDR, CMD_DATA})) gap_cnt_q <= '0;
    else                                                         gap_cnt_q <= gap_cnt_q + 1'b1;
  end
`else
  // Timeout not built; the parameter stays for interface compatibility
  localparam int unsigned timeout_unused = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  // Next-state and per-cycle strobes
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d    = state_q;
    accept     = 1'b0;
    shift_addr = 1'b0;
    shift_data = 1'b0;
    load_rsp   = 1'b0;
    load_rd    = 1'b0;
    rsp_byte   = '0;
    send_c     = 1'b0;
    flag_clr_c = 1'b0;
    wr_c       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_ready) begin
          accept = 1'b1;
          if (parity_error) begin
            load_rsp = 1'b1;
            rsp_byte = RSP_PARITY;
            state_d  = TX_LOAD;
          end else if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
            state_d = CMD_ADDR;
          end else begin
            load_rsp = 1'b1;
            rsp_byte = RSP_BAD_CMD;
            state_d  = TX_LOAD;
          end
        end
      end
      CMD_ADDR, CMD_DATA: begin
        if (rx_ready) begin
          accept = 1'b1;
          if (parity_error) begin
            load_rsp = 1'b1;
            rsp_byte = RSP_PARITY;
            state_d  = TX_LOAD;
          end else if (state_q == CMD_ADDR) begin
            shift_addr = 1'b1;
            if (byte_cnt_q == LAST_FIELD_BYTE) state_d = is_write_q ? CMD_DATA : MMIO_RD;
          end else begin
            shift_data = 1'b1;
            if (byte_cnt_q == LAST_FIELD_BYTE) state_d = MMIO_WR;
          end
        end else if (timeout_hit) begin
          state_d = IDLE;
        end
      end
      MMIO_WR: begin
        wr_c     = 1'b1;
        load_rsp = 1'b1;
        rsp_byte = RSP_OK;
        state_d  = TX_LOAD;
      end
      MMIO_RD: begin
        if (rd_wait_q) begin
          load_rd = 1'b1;
          state_d = TX_LOAD;
        end
      end
      TX_LOAD: begin
        send_c  = 1'b1;
        state_d = TX_WAIT;
      end
      TX_WAIT: begin
        if (tx_flag) begin
          flag_clr_c = 1'b1;
          state_d    = (tx_left_q > 3'd1) ? TX_LOAD : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register see pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Frame assembler: command flag, byte counter, address and data shifters
  always_ff @(posedge clk) begin
    if (rst) begin
      is_write_q <= 1'b0;
      byte_cnt_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rx_skip_q  <= 1'b0;
      rd_wait_q  <= 1'b0;
    end else begin
      rx_skip_q <= accept;
      rd_wait_q <= (state_q == MMIO_RD) && !rd_wait_q;
      if (state_q == IDLE && accept) is_write_q <= (rx_data == CMD_WRITE);
      if (state_q == IDLE)                byte_cnt_q <= '0;
      else if (shift_addr || shift_data)  byte_cnt_q <= byte_cnt_q + 2'd1;
      if (shift_addr) addr_q <= {rx_data, addr_q[ADDRESS_32_W-1:UART_DATA_WIDTH]};
      if (shift_data) data_q <= {rx_data, data_q[DATA_32_W-1:UART_DATA_WIDTH]};
    end
  end

  // Response queue: loaded once per frame, shifted as each byte is acknowledged
  always_ff @(posedge clk) begin
    if (rst) begin
      txq_q     <= '0;
      tx_left_q <= '0;
    end else if (load_rsp) begin
      txq_q     <= DATA_32_W'(rsp_byte);
      tx_left_q <= 3'd1;
    end else if (load_rd) begin
      txq_q     <= data_mmio_rd_data;
      tx_left_q <= 3'd4;
    end else if (flag_clr_c) begin
      txq_q     <= txq_q >> UART_DATA_WIDTH;
      tx_left_q <= tx_left_q - 3'd1;
    end
  end

  // Outputs are forced low while reset is asserted
  assign rx_flag_clr           = accept && !rst;
  assign tx_send               = send_c && !rst;
  assign tx_flag_clr           = flag_clr_c && !rst;
  assign data_mmio_wr_addr_val = wr_c && !rst;
  assign busy                  = (state_q != IDLE) && !rst;
  assign data_mmio_addr        = rst ? '0 : addr_q;
  assign data_mmio_wr_data     = rst ? '0 : data_q;
  assign tx_data               = rst ? '0 : txq_q[UART_DATA_WIDTH-1:0];

endmodule : uart_mmio_bridge

// File: tb/tb_uart_mmio_bridge.sv
// tb_uart_mmio_bridge: directed, table-driven bench for uart_mmio_bridge with
// behavioural UART RX/TX handshakes and a single-word MMIO read model.
module tb_uart_mmio_bridge;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_flag;
  logic        parity_error;
  logic        rx_flag_clr;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_flag;
  logic        tx_flag_clr;
  logic [31:0] data_mmio_addr;
  logic        data_mmio_wr_addr_val;
  logic [31:0] data_mmio_wr_data;
  logic [31:0] data_mmio_rd_data;
  logic        busy;

  logic [31:0] mem_addr, mem_data;
  assign data_mmio_rd_data = (data_mmio_addr == mem_addr) ? mem_data : 32'hBAD0_BAD0;

  always #5 clk = ~clk;

  uart_mmio_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .rx_data              (rx_data),
    .rx_flag              (rx_flag),
    .parity_error         (parity_error),
    .rx_flag_clr          (rx_flag_clr),
    .tx_data              (tx_data),
    .tx_send              (tx_send),
    .tx_flag              (tx_flag),
    .tx_flag_clr          (tx_flag_clr),
    .data_mmio_addr       (data_mmio_addr),
    .data_mmio_wr_addr_val(data_mmio_wr_addr_val),
    .data_mmio_wr_data    (data_mmio_wr_data),
    .data_mmio_rd_data    (data_mmio_rd_data),
    .busy                 (busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard fed by an output monitor sampling on the falling edge
  logic [7:0]  tx_log[$];
  int          wr_count = 0;
  logic [31:0] wr_addr_seen, wr_data_seen;

  always @(negedge clk) begin
    if (tx_send) tx_log.push_back(tx_data);
    if (data_mmio_wr_addr_val) begin
      wr_count++;
      wr_addr_seen = data_mmio_addr;
      wr_data_seen = data_mmio_wr_data;
    end
  end

  // Transmitter model: finish each byte a few cycles after tx_send
  int tx_hs_errors = 0;
  initial begin
    bit abort, seen;
    tx_flag = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_send) begin
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          if (rst) abort = 1'b1;
        end
        if (!abort) begin
          tx_flag = 1'b1;
          seen = 1'b0;
          for (int i = 0; i < 20 && !seen && !rst; i++) begin
            #1;
            if (tx_flag_clr) seen = 1'b1;
            else @(negedge clk);
          end
          if (!seen && !rst) tx_hs_errors++;
          @(posedge clk);
          #1 tx_flag = 1'b0;
        end
      end
    end
  end

  function automatic logic [127:0] out_vec();
    return {51'd0, rx_flag_clr, tx_send, tx_flag_clr, data_mmio_wr_addr_val, busy,
            tx_data, data_mmio_addr, data_mmio_wr_data};
  endfunction

  // Present one byte and hold it until the bridge acknowledges it
  task automatic send_byte(input logic [7:0] b, input logic p);
    bit got = 1'b0;
    @(negedge clk);
    rx_data = b;
    parity_error = p;
    rx_flag = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      if (rx_flag_clr) got = 1'b1;
      @(posedge clk);
    end
    #1;
    rx_flag = 1'b0;
    parity_error = 1'b0;
    check($sformatf("rx accept %0h", b), got, 1'b1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    check(name, done, 1'b1);
  endtask

  task automatic check_tx(input string name, input int n, input logic [31:0] exp);
    check({name, " tx count"}, tx_log.size(), n);
    for (int i = 0; i < n; i++)
      check($sformatf("%s tx byte %0d", name, i),
            (i < tx_log.size()) ? tx_log[i] : 8'h00, exp[8*i +: 8]);
  endtask

  task automatic check_write(input string name, input logic [31:0] a, input logic [31:0] d);
    check({name, " wr count"}, wr_count, 1);
    check({name, " wr addr"}, wr_addr_seen, a);
    check({name, " wr data"}, wr_data_seen, d);
  endtask

  typedef struct {
    int          nbytes;
    logic [71:0] bytes;     // byte i in [8*i +: 8]
    int          par_idx;   // byte carrying parity_error, -1 for none
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    int          exp_tx_n;
    logic [31:0] exp_tx;    // byte i in [8*i +: 8]
    int          exp_wr;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   clr_while_busy;
    bit   done;
    string nm;

    vecs[0] = '{9, 72'hDE_AD_BE_EF_40_00_00_10_57, -1, 32'h0, 32'h0, 1, 32'h4B, 1, 32'h4000_0010, 32'hDEAD_BEEF};
    vecs[1] = '{5, 72'h40_00_00_04_52, -1, 32'h4000_0004, 32'h1234_5678, 4, 32'h1234_5678, 0, 32'h0, 32'h0};
    vecs[2] = '{1, 72'h00, -1, 32'h0, 32'h0, 1, 32'h3F, 0, 32'h0, 32'h0};
    vecs[3] = '{3, 72'h00_10_57, 2, 32'h0, 32'h0, 1, 32'h45, 0, 32'h0, 32'h0};
    vecs[4] = '{9, 72'h80_00_00_01_7F_FF_FF_FC_57, -1, 32'h0, 32'h0, 1, 32'h4B, 1, 32'h7FFF_FFFC, 32'h8000_0001};
    vecs[5] = '{5, 72'h03_02_01_00_52, -1, 32'h0302_0100, 32'hCAFE_F00D, 4, 32'hCAFE_F00D, 0, 32'h0, 32'h0};
    vecs[6] = '{1, 72'h77, -1, 32'h0, 32'h0, 1, 32'h3F, 0, 32'h0, 32'h0};
    vecs[7] = '{1, 72'h57, 0, 32'h0, 32'h0, 1, 32'h45, 0, 32'h0, 32'h0};
    vecs[8] = '{5, 72'h11_00_00_00_52, 4, 32'h0, 32'h0, 1, 32'h45, 0, 32'h0, 32'h0};

    rst = 1'b1;
    rx_data = '0;
    rx_flag = 1'b0;
    parity_error = 1'b0;
    mem_addr = '0;
    mem_data = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("outputs during reset", out_vec(), '0);
    rst = 1'b0;
    @(negedge clk);
    check("outputs after reset", out_vec(), '0);

    // Table-driven frames
    for (int k = 0; k < 9; k++) begin
      v = vecs[k];
      nm = $sformatf("vec%0d", k);
      mem_addr = v.mem_addr;
      mem_data = v.mem_data;
      tx_log.delete();
      wr_count = 0;
      for (int i = 0; i < v.nbytes; i++) send_byte(v.bytes[8*i +: 8], (i == v.par_idx));
      wait_idle({nm, " idle"}, 200);
      check_tx(nm, v.exp_tx_n, v.exp_tx);
      if (v.exp_wr != 0) check_write(nm, v.exp_addr, v.exp_data);
      else               check({nm, " wr count"}, wr_count, 0);
    end

    // rx_flag held high across an accept is ignored for one cycle
    tx_log.delete();
    wr_count = 0;
    mem_addr = 32'h0000_0052;
    mem_data = 32'hA1B2_C3D4;
    @(negedge clk);
    rx_data = 8'h52;
    rx_flag = 1'b1;
    #1 check("skip first clr", rx_flag_clr, 1'b1);
    @(negedge clk);
    check("skip hold cycle", rx_flag_clr, 1'b0);
    @(negedge clk);
    check("skip reaccept", rx_flag_clr, 1'b1);
    @(posedge clk);
    #1 rx_flag = 1'b0;
    for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b0);
    wait_idle("skip idle", 200);
    check_tx("skip", 4, 32'hA1B2_C3D4);
    check("skip wr count", wr_count, 0);

    // Bytes arriving while responding are not acknowledged until IDLE
    tx_log.delete();
    send_byte(8'h00, 1'b0);
    @(negedge clk);
    rx_data = 8'h00;
    rx_flag = 1'b1;
    clr_while_busy = 0;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
      else if (rx_flag_clr) clr_while_busy++;
    end
    check("busy rx no clr", clr_while_busy, 0);
    check("busy rx clr at idle", rx_flag_clr, 1'b1);
    @(posedge clk);
    #1 rx_flag = 1'b0;
    wait_idle("busy rx idle", 200);
    check_tx("busy rx", 2, 32'h0000_3F3F);

    // Reset while waiting for the transmitter during a read response
    tx_log.delete();
    mem_addr = 32'h4000_0004;
    mem_data = 32'h1234_5678;
    send_byte(8'h52, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h40, 1'b0);
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (tx_log.size() >= 1) done = 1'b1;
    end
    check("rst first tx seen", done, 1'b1);
    @(negedge clk);
    check("rst in tx wait", busy, 1'b1);
    rst = 1'b1;
    #1 check("rst outputs during", out_vec(), '0);
    @(negedge clk);
    check("rst outputs next cycle", out_vec(), '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("rst no further tx", tx_log.size(), 1);
    check("rst busy low", busy, 1'b0);

    // Partial frame: abandoned after the timeout, or held indefinitely
    tx_log.delete();
    wr_count = 0;
    send_byte(8'h57, 1'b0);
    send_byte(8'h10, 1'b0);
`ifdef UART_BRIDGE_TIMEOUT_EN
    repeat (TO - 1) @(posedge clk);
    #1 check("timeout not yet", busy, 1'b1);
    @(posedge clk);
    #1 check("timeout idle", busy, 1'b0);
    repeat (5) @(negedge clk);
    check("timeout wr count", wr_count, 0);
    check("timeout tx count", tx_log.size(), 0);
    send_byte(8'h57, 1'b0);
    send_byte(8'h10, 1'b0);
`else
    repeat (TO + 50) @(negedge clk);
    check("partial frame waits", busy, 1'b1);
    check("partial frame no wr", wr_count, 0);
`endif
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h40, 1'b0);
    send_byte(8'hEF, 1'b0);
    send_byte(8'hBE, 1'b0);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hDE, 1'b0);
    wait_idle("after partial idle", 200);
    check_write("after partial", 32'h4000_0010, 32'hDEAD_BEEF);
    check_tx("after partial", 1, 32'h4B);

    check("tx handshake errors", tx_hs_errors, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_mmio_bridge
